rr_gate_arbiter: RTL and testbench
==================================

// Module: rr_gate_arbiter
// PURPOSE
//  Round-robin arbiter sharing one combinational logic unit (gate/ALU slice) among N requesters.
//  Grants ownership one requester at a time, with no preemption.
//  Rotates priority after each release so that no requester starves.
//  Sits between requester FSMs and the shared unit's input mux; gnt drives the mux select.
// PARAMETERS
//  N         4   number of requesters (>=2)
//  IDW       2   width of gnt_id; must equal clog2(N)
//  MAX_HOLD  16  max cycles one grant may be held; used only when ARB_TIMEOUT_EN is defined
// PORTS
//  clk      in   1    rising-edge clock
//  rst_n    in   1    synchronous reset, active-low
//  req      in   N    request vector; req[i]=1 means requester i wants the unit
//  done     in   1    current owner finished; sampled only in GRANT
//  gnt      out  N    registered one-hot grant; all-zero when no owner
//  gnt_id   out  IDW  binary index of the owner; valid while busy=1
//  busy     out  1    1 while a grant is active (equals |gnt)
//  timeout  out  1    1-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, ptr=0.
//    Reset mid-grant drops gnt at that edge; no release bookkeeping is done.
//  - ptr is the internal priority pointer; index ptr has highest priority.
//  - Search order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wraps modulo N).
//  - IDLE: if |req=1 at the edge, grant the first set req bit in search order.
//    gnt/gnt_id/busy are registered, so latency is 1 cycle from req to gnt. Next state: GRANT.
//  - IDLE with req=0: stay in IDLE; outputs hold at 0. done is ignored in IDLE.
//  - GRANT: gnt held stable while req[owner]=1 and done=0.
//    Other requests are ignored; there is no preemption.
//  - Release condition: done=1 OR req[owner]=0 at the edge. Then:
//    gnt=0 and busy=0 next cycle; ptr=(owner+1) mod N; state=IDLE.
//    done=1 and a req drop in the same cycle count as a single release.
//  - There is a mandatory 1-cycle bubble (gnt=0) between consecutive grants.
//    A new request arriving in the release cycle is arbitrated in the following IDLE cycle.
//  - Invariants: gnt is one-hot or zero; gnt changes only at a grant or a release edge;
//    gnt_id always matches gnt when busy=1.
//  - FSM has 2 states, IDLE(0) and GRANT(1); no other states are reachable.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//  - hold_cnt (width clog2(MAX_HOLD)+1) clears on entry to GRANT and increments each GRANT cycle.
//  - If the grant has been held MAX_HOLD cycles with no normal release, it is force-released:
//    gnt=0 next cycle, timeout=1 for exactly that cycle, ptr advances as on a normal release.
//  - A normal release in the same cycle as the timeout takes precedence (timeout stays 0).
//  ARB_TIMEOUT_EN undefined:
//  - No counter is built; timeout is tied 0; a grant is held indefinitely until released.
// TESTING
//  T1 reset, req=4'b0000 for 5 cycles -> gnt=0, busy=0, timeout=0 throughout
//  T2 after reset, req=4'b1010 -> next cycle gnt=4'b0010, gnt_id=1;
//     done pulse -> gnt=0 one cycle, then gnt=4'b1000, gnt_id=3
//  T3 req=4'b1111 held, done pulsed once per grant -> grant order 0001, 0010, 0100, 1000, 0001,
//     each separated by one gnt=0 cycle
//  T4 owner 3 releases (ptr wraps to 0), req=4'b1001 -> gnt=4'b0001;
//     owner drops req without done -> release identical to done
//  T5 rst_n=0 while gnt=4'b0100 -> gnt=0 next edge;
//     after reset, req=4'b1111 -> gnt=4'b0001 (ptr back to 0)
//  T6 ARB_TIMEOUT_EN, MAX_HOLD=4, req=4'b0001 held, done=0 -> gnt=0001 for 4 cycles,
//     then gnt=0 with timeout=1 for 1 cycle, then re-grant 0001;
//     without the macro, gnt stays 0001 and timeout stays 0

Source files
------------

// File: rtl/rr_gate_arbiter.sv
// Round-robin arbiter that hands one shared combinational unit to one of N requesters at a time.
// Optional forced release after MAX_HOLD cycles is built only when ARB_TIMEOUT_EN is defined.
module rr_gate_arbiter #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [N-1:0]    gnt_reg, gnt_next;
    logic [IDW-1:0]  gnt_id_reg, gnt_id_next;
    logic [IDW-1:0]  ptr_reg, ptr_next;
    logic            timeout_reg, timeout_next;

    // Parameter sanity, caught at elaboration time.
    if (N < 2 || IDW != $clog2(N) || MAX_HOLD < 1) begin : g_bad_params
        $error("rr_gate_arbiter: illegal parameter combination");
    end

    // Candidate index for each search position: (ptr + position) mod N.
    logic [IDW-1:0] cand_idx [N];
    logic [N-1:0]   cand_req;
    logic [N-1:0]   pick_onehot;

    for (genvar gi = 0; gi < N; gi++) begin : g_search
        logic [IDW:0] pos_sum;
        assign pos_sum       = {1'b0, ptr_reg} + (IDW+1)'(gi);
        assign cand_idx[gi]  = (pos_sum >= (IDW+1)'(N)) ? IDW'(pos_sum - (IDW+1)'(N))
                                                        : IDW'(pos_sum);
        assign cand_req[gi]  = req[cand_idx[gi]];
    end

    logic           pick_valid;
    logic [IDW-1:0] pick_idx;

    // Walk from the lowest-priority position upward so the earliest hit wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx[k];
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_decode
        assign pick_onehot[gi] = (pick_idx == IDW'(gi));
    end

    logic           owner_req;
    logic           release_now;
    logic [IDW-1:0] owner_plus1;

    assign owner_req   = req[gnt_id_reg];
    assign release_now = done || !owner_req;
    assign owner_plus1 = (gnt_id_reg == IDW'(N - 1)) ? '0 : gnt_id_reg + 1'b1;

    logic hold_expired;

`ifdef ARB_TIMEOUT_EN
    localparam int HCW = $clog2(MAX_HOLD) + 1;

    logic [HCW-1:0] hold_cnt_reg, hold_cnt_next;

    // Counter reads 0 in the first GRANT cycle, so MAX_HOLD-1 marks the last allowed cycle.
    assign hold_expired = (state_reg == GRANT) && (hold_cnt_reg == HCW'(MAX_HOLD - 1));

    always_comb begin
        hold_cnt_next = '0;
        if (state_reg == GRANT) begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt_reg <= '0;
        end else begin
            hold_cnt_reg <= hold_cnt_next;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        gnt_next     = gnt_reg;
        gnt_id_next  = gnt_id_reg;
        ptr_next     = ptr_reg;
        timeout_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next  = GRANT;
                    gnt_next    = pick_onehot;
                    gnt_id_next = pick_idx;
                end
            end
            GRANT: begin
                // A normal release wins over a coincident timeout.
                if (release_now || hold_expired) begin
                    state_next   = IDLE;
                    gnt_next     = '0;
                    gnt_id_next  = '0;
                    ptr_next     = owner_plus1;
                    timeout_next = !release_now;
                end
            end
            default: begin
                state_next  = IDLE;
                gnt_next    = '0;
                gnt_id_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            gnt_reg     <= '0;
            gnt_id_reg  <= '0;
            ptr_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            gnt_reg     <= gnt_next;
            gnt_id_reg  <= gnt_id_next;
            ptr_reg     <= ptr_next;
            timeout_reg <= timeout_next;
        end
    end

    assign gnt     = gnt_reg;
    assign gnt_id  = gnt_id_reg;
    assign busy    = |gnt_reg;
    assign timeout = timeout_reg;

endmodule

// File: tb/tb_rr_gate_arbiter.sv
// Randomized and directed bench for rr_gate_arbiter against a cycle-level owner/pointer model.
// Honors ARB_TIMEOUT_EN so the model matches whichever build is compiled.
module tb_rr_gate_arbiter;

    localparam int N        = 4;
    localparam int IDW      = 2;
    localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic           done;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout;

    rr_gate_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    // Reference model: who owns the unit, whose turn is next, how long the grant has lasted.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_tout  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_update(input bit r_n, input logic [N-1:0] rq, input bit dn);
        bit rel;
        bit expired;
        if (!r_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
            m_tout  = 1'b0;
        end else if (m_owner < 0) begin
            m_tout = 1'b0;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (rq[idx]) begin
                    m_owner = idx;
                    m_hold  = 0;
                    break;
                end
            end
        end else begin
            rel     = dn || !rq[m_owner];
            m_hold  = m_hold + 1;
            expired = TO_EN && (m_hold >= MAX_HOLD);
            if (rel || expired) begin
                m_tout  = !rel;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_tout = 1'b0;
            end
        end
    endtask

    task automatic step(input bit r_n, input logic [N-1:0] rq, input bit dn);
        logic [N-1:0] exp_gnt;
        rst_n = r_n;
        req   = rq;
        done  = dn;
        @(posedge clk);
        model_update(r_n, rq, dn);
        #1;
        cyc++;
        exp_gnt = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        $display("cyc %0d rst_n=%0b req=%b done=%0b -> gnt=%b id=%0d busy=%0b timeout=%0b",
                 cyc, r_n, rq, dn, gnt, gnt_id, busy, timeout);
        check_eq("gnt", 32'(gnt), 32'(exp_gnt));
        check_eq("busy", 32'(busy), 32'(m_owner >= 0));
        check_eq("timeout", 32'(timeout), 32'(m_tout));
        if (m_owner >= 0) check_eq("gnt_id", 32'(gnt_id), 32'(m_owner));
    endtask

    initial begin
        logic [N-1:0] req_r;
        logic [N-1:0] order [5];
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;

        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;

        // T1: reset, then idle with no requests.
        step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        check_eq("T1 reset gnt_id", 32'(gnt_id), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b0000, 1'b0);
            check_eq("T1 idle gnt", 32'(gnt), 32'd0);
        end

        // T2: ptr 0 picks requester 1, then after release ptr 2 picks requester 3.
        step(1'b1, 4'b1010, 1'b0);
        check_eq("T2 gnt", 32'(gnt), 32'b0010);
        check_eq("T2 gnt_id", 32'(gnt_id), 32'd1);
        step(1'b1, 4'b1010, 1'b1);
        check_eq("T2 bubble", 32'(gnt), 32'd0);
        step(1'b1, 4'b1010, 1'b0);
        check_eq("T2 gnt2", 32'(gnt), 32'b1000);
        check_eq("T2 gnt_id2", 32'(gnt_id), 32'd3);
        step(1'b1, 4'b1010, 1'b1);

        // T3: all requesting, rotation through every requester.
        for (int g = 0; g < 5; g++) begin
            step(1'b1, 4'b1111, 1'b0);
            check_eq("T3 order", 32'(gnt), 32'(order[g]));
            step(1'b1, 4'b1111, 1'b1);
            check_eq("T3 bubble", 32'(gnt), 32'd0);
        end

        // T4: owner 3 release wraps ptr to 0; req drop releases like done.
        step(1'b1, 4'b1000, 1'b0);
        step(1'b1, 4'b1000, 1'b1);
        step(1'b1, 4'b1001, 1'b0);
        check_eq("T4 wrap gnt", 32'(gnt), 32'b0001);
        step(1'b1, 4'b1000, 1'b0);
        check_eq("T4 drop release", 32'(gnt), 32'd0);
        step(1'b1, 4'b1000, 1'b0);
        check_eq("T4 regrant", 32'(gnt), 32'b1000);
        step(1'b1, 4'b0000, 1'b0);

        // T5: reset mid-grant, pointer returns to 0.
        step(1'b1, 4'b0100, 1'b0);
        check_eq("T5 gnt", 32'(gnt), 32'b0100);
        step(1'b0, 4'b0100, 1'b0);
        check_eq("T5 reset drop", 32'(gnt), 32'd0);
        step(1'b1, 4'b1111, 1'b0);
        check_eq("T5 after reset", 32'(gnt), 32'b0001);
        step(1'b1, 4'b0000, 1'b1);

        // T6: long hold with done low; the model decides whether a timeout occurs.
        for (int i = 0; i < 12; i++) step(1'b1, 4'b0001, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0000, 1'b0);

        // Randomized traffic with slowly changing request patterns.
        req_r = '0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) req_r = req_r ^ N'(1 << $urandom_range(0, N - 1));
            step(($urandom_range(0, 199) != 0), req_r, ($urandom_range(0, 5) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
